count_updn: RTL
===============

COUNT_UPDN -- requirements
Module: count_updn

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the counter register width in bits (1..32).
REQ-002 SHALL have parameter MOD_MAX, default 255, meaning the top count value; the count range is 0..MOD_MAX, and MOD_MAX SHALL be at most 2**WIDTH-1.
REQ-003 SHALL have parameter PRESC, default 4, meaning clock cycles per count step (2..65535).
REQ-004 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at the bounds and 1 = hold at the bounds.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit, an asynchronous, active-low reset.
REQ-007 SHALL have port en_i, input, 1 bit, enabling the prescaler and counting.
REQ-008 SHALL have port dir_i, input, 1 bit, giving the direction: 0 = up, 1 = down.
REQ-009 SHALL have port load_i, input, 1 bit, a synchronous load strobe.
REQ-010 SHALL have port load_val_i, input, WIDTH bits, the load value.
REQ-011 SHALL have port clear_i, input, 1 bit, a synchronous clear strobe.
REQ-012 SHALL have port count_o, output, WIDTH bits, the current count (registered).
REQ-013 SHALL have port tick_o, output, 1 bit, a one-cycle step strobe.
REQ-014 SHALL have port tc_o, output, 1 bit, a one-cycle terminal-count strobe.

Function
REQ-015 SHALL hold an internal prescaler counter p in 0..PRESC-1; when en_i=1, p increments each cycle and wraps from PRESC-1 to 0; when en_i=0, p holds.
REQ-016 SHALL drive tick_o = en_i AND (p == PRESC-1), combinationally; a step occurs in every cycle where tick_o=1.
REQ-017 SHALL apply priority per cycle as clear_i, then load_i, then step; clear_i and load_i act immediately and are not gated by tick_o or en_i.
REQ-018 SHALL, on clear_i=1, set count_o to 0 and p to 0 at the next edge.
REQ-019 SHALL, on load_i=1 with clear_i=0, set count_o to min(load_val_i, MOD_MAX) at the next edge, leaving p unchanged.
REQ-020 SHALL, on a step going up, move count_o to count_o+1; at MOD_MAX it moves to 0 if SATURATE=0 and holds MOD_MAX if SATURATE=1.
REQ-021 SHALL, on a step going down, move count_o to count_o-1; at 0 it moves to MOD_MAX if SATURATE=0 and holds 0 if SATURATE=1.
REQ-022 SHALL drive tc_o = step AND ((dir_i=0 AND count_o==MOD_MAX) OR (dir_i=1 AND count_o==0)), in the same cycle as the step; the strobe SHALL repeat on every step taken at a bound in saturate mode.
REQ-023 SHALL force tc_o=0 whenever clear_i or load_i is 1.
REQ-024 SHALL sample dir_i at each step; a direction change mid-count takes effect on the next step, with no lost or extra steps.
REQ-025 SHALL keep count_o within 0..MOD_MAX at all times, including the MOD_MAX < 2**WIDTH-1 case.

Reset
REQ-026 SHALL, while rst_ni=0, immediately force count_o=0 and p=0 regardless of clk_i, giving tick_o=0 and tc_o=0.
REQ-027 SHALL make the first tick_o after rst_ni deasserts, with en_i held at 1, occur on the PRESC-th rising edge.
REQ-028 SHALL, when reset asserts mid-count, discard all state with no partial step.

Configuration
REQ-029 SHALL use macro COUNT_UPDN_PRESC_EN to compile the prescaler in or out.
REQ-030 SHALL, when COUNT_UPDN_PRESC_EN is defined, implement the prescaler as in REQ-015 and REQ-016.
REQ-031 SHALL, when COUNT_UPDN_PRESC_EN is undefined, omit p, ignore PRESC and drive tick_o = en_i, so the counter steps every enabled cycle; all other requirements still apply.

Verification (WIDTH=3, MOD_MAX=5, PRESC=4, macro defined unless noted)
REQ-032 SHALL cover reset: rst_ni=0 for 3 cycles -> count_o=0, tick_o=0, tc_o=0; after release with en_i=1, the first tick_o on edge 4.
REQ-033 SHALL cover wrap up: en_i=1, dir_i=0 for 24 cycles -> count_o 1,2,3,4,5,0 changing every 4 cycles, with tc_o high exactly once, on the 5->0 step.
REQ-034 SHALL cover wrap down: from 0, dir_i=1 -> count_o 5,4,... and tc_o pulses on the 0->5 step; a dir_i flip at count 3 -> next step gives 4.
REQ-035 SHALL cover load and clear: load_val_i=7 with load_i -> count_o=5; load_i and clear_i together -> count_o=0, p=0, tc_o=0.
REQ-036 SHALL cover saturate: SATURATE=1 with an up count at 5 -> count_o stays 5 and tc_o pulses on every tick_o; reverse to dir_i=1 -> count_o=4.
REQ-037 SHALL cover no prescaler: macro undefined, en_i=1, dir_i=0 -> count_o increments every cycle, wraps 5->0, and tick_o equals en_i.

Source files
------------

// File: rtl/count_updn.sv
// Up/down counter over 0..MOD_MAX with prescaled stepping, load, clear and a terminal-count strobe.
// Define COUNT_UPDN_PRESC_EN to build in the prescaler; otherwise the counter steps on every enabled cycle.
module count_updn #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_MAX  = 255,
    parameter int unsigned PRESC    = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD_MAX);
    localparam bit               LP_SAT = (SATURATE != 0);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("count_updn: WIDTH must be in 1..32");
    end
    if (64'(MOD_MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("count_updn: MOD_MAX does not fit in WIDTH bits");
    end
    if (PRESC < 2 || PRESC > 65535) begin : g_bad_presc
        $error("count_updn: PRESC must be in 2..65535");
    end
    if (SATURATE > 1) begin : g_bad_sat
        $error("count_updn: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_tick;
    logic             w_at_bound;
    logic             w_tc;

`ifdef COUNT_UPDN_PRESC_EN
    localparam int unsigned        LP_PW    = $clog2(PRESC);
    localparam logic [LP_PW-1:0]   LP_PLAST = LP_PW'(PRESC - 1);

    logic [LP_PW-1:0] r_presc;
    logic [LP_PW-1:0] w_presc_nxt;

    // Load does not touch the prescaler; only clear realigns it.
    always_comb begin
        w_presc_nxt = r_presc;
        if (clear_i) begin
            w_presc_nxt = '0;
        end else if (en_i) begin
            w_presc_nxt = (r_presc == LP_PLAST) ? '0 : r_presc + LP_PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_presc_nxt;
        end
    end

    assign w_tick = en_i && (r_presc == LP_PLAST);
`else
    // Without a prescaler register there is nothing for reset to clear, so gate it here.
    assign w_tick = en_i && rst_ni;
`endif

    always_comb begin
        w_load_clamped = (load_val_i > LP_MAX) ? LP_MAX : load_val_i;
        w_at_bound     = dir_i ? (r_count == '0) : (r_count >= LP_MAX);
        w_count_nxt    = r_count;
        if (clear_i) begin
            w_count_nxt = '0;
        end else if (load_i) begin
            w_count_nxt = w_load_clamped;
        end else if (w_tick) begin
            if (!dir_i) begin
                if (r_count >= LP_MAX) begin
                    w_count_nxt = LP_SAT ? LP_MAX : '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_count_nxt = LP_SAT ? '0 : LP_MAX;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign w_tc = w_tick && !clear_i && !load_i && w_at_bound;

    assign count_o = r_count;
    assign tick_o  = w_tick;
    assign tc_o    = w_tc;

endmodule
